// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, control FSM states
// and small decode helpers used by the top and the test bench.
package alu_pkg;

    localparam int unsigned ALU_FUNCT_W = 4;

    typedef enum logic [ALU_FUNCT_W-1:0] {
        FnLoad = 4'd0,
        FnSum  = 4'd1,
        FnSub  = 4'd2,
        FnAnd  = 4'd3,
        FnXor  = 4'd4,
        FnNot  = 4'd5,
        FnInc  = 4'd6,
        FnOr   = 4'd7,
        FnSll  = 4'd8,
        FnSrl  = 4'd9,
        FnSra  = 4'd10,
        FnMul  = 4'd11,
        FnDiv  = 4'd12,
        FnDivu = 4'd13,
        FnRem  = 4'd14,
        FnRemu = 4'd15
    } alu_funct_e;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } alu_state_e;

    function automatic logic is_div_op(alu_funct_e f);
        return f inside {FnDiv, FnDivu, FnRem, FnRemu};
    endfunction

    function automatic logic is_signed_div(alu_funct_e f);
        return f inside {FnDiv, FnRem};
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-step multiply (shift-add) and restoring divide on unsigned operands.
// Mul: acc = product, lo = multiplier, op = multiplicand. Div: acc = remainder, lo = quotient.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             step,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] lo
);

    logic             div_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [WIDTH:0]   trial, diff;

    always_comb begin
        acc_d = acc_q;
        lo_d  = lo_q;
        op_d  = op_q;
        trial = {acc_q, lo_q[WIDTH-1]};
        diff  = trial - {1'b0, op_q};
        if (div_q) begin
            // Borrow out of the trial subtraction means the divisor did not fit.
            if (!diff[WIDTH]) begin
                acc_d = diff[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = trial[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (lo_q[0]) begin
                acc_d = acc_q + op_q;
            end
            op_d = op_q << 1;
            lo_d = lo_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= 1'b0;
            acc_q <= '0;
            lo_q  <= '0;
            op_q  <= '0;
        end else if (start) begin
            div_q <= is_div;
            acc_q <= '0;
            lo_q  <= is_div ? op_a : op_b;
            op_q  <= is_div ? op_b : op_a;
        end else if (step) begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            op_q  <= op_d;
        end
    end

    assign acc      = acc_q;
    assign acc_next = acc_d;
    assign lo       = lo_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/shift ops, iterative MUL/DIV/REM,
// registered result and status flags behind a valid/ready pair.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ALU_FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       result,
    output logic                   overflow,
    output logic                   negative,
    output logic                   zero,
    output logic                   equal,
    output logic                   greater,
    output logic                   less,
    output logic                   div_zero
);

    localparam int unsigned       SHW  = $clog2(WIDTH);
    localparam int unsigned       CNTW = SHW + 1;
    localparam logic [CNTW-1:0]   LAST = CNTW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    alu_state_e       state_q, state_d, accept_state;
    alu_funct_e       fn, funct_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CNTW-1:0]  cnt_q;
    logic             accept, start, step;
    logic             div_op, div_signed, dz, sovf, special;
    logic [WIDTH-1:0] simple_res;
    logic             simple_ovf;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] it_acc, it_acc_next, it_lo;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             load, ld_ovf, ld_dz;
    logic [WIDTH-1:0] ld_res, ld_a, ld_b;

    assign fn = alu_funct_e'(funct);

    // Decode, special cases and single-cycle results, all from the live request.
    always_comb begin
        div_op     = is_div_op(fn);
        div_signed = is_signed_div(fn);
        dz         = div_op && (b == '0);
        sovf       = div_signed && (a == MIN) && (b == '1);
        special    = dz || sovf;
        simple_res = '0;
        simple_ovf = 1'b0;
        case (fn)
            FnLoad: simple_res = a;
            FnSum: begin
                simple_res = a + b;
                simple_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (simple_res[WIDTH-1] != a[WIDTH-1]);
            end
            FnSub: begin
                simple_res = a - b;
                simple_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (simple_res[WIDTH-1] != a[WIDTH-1]);
            end
            FnAnd:         simple_res = a & b;
            FnXor:         simple_res = a ^ b;
            FnNot:         simple_res = ~a;
            FnInc:         simple_res = a + WIDTH'(1);
            FnOr:          simple_res = a | b;
            FnSll:         simple_res = a << b[SHW-1:0];
            FnSrl:         simple_res = a >> b[SHW-1:0];
            FnSra:         simple_res = $signed(a) >>> b[SHW-1:0];
            FnDiv, FnDivu: begin
                simple_res = dz ? '1 : a;
                simple_ovf = sovf;
            end
            FnRem, FnRemu: begin
                simple_res = dz ? a : '0;
                simple_ovf = sovf;
            end
            default:       simple_res = '0;
        endcase
        mag_a        = (div_signed && a[WIDTH-1]) ? -a : a;
        mag_b        = (div_signed && b[WIDTH-1]) ? -b : b;
        accept_state = (fn == FnMul) ? StMul : (div_op && !special) ? StDiv : StDone;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = accept_state;
            StMul:   if (cnt_q == LAST) state_d = StDone;
            StDiv:   if (cnt_q == LAST) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  if (out_ready) state_d = accept ? accept_state : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
        out_valid = (state_q == StDone);
        accept    = in_valid && in_ready;
        start     = accept && ((fn == FnMul) || (div_op && !special));
        step      = (state_q == StMul) || (state_q == StDiv);
    end

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .is_div  (div_op),
        .step    (step),
        .op_a    (mag_a),
        .op_b    (mag_b),
        .acc     (it_acc),
        .acc_next(it_acc_next),
        .lo      (it_lo)
    );

    // Sign fix-up: quotient negative when signs differ, remainder follows the dividend.
    always_comb begin
        quo_fix = (is_signed_div(funct_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -it_lo : it_lo;
        rem_fix = (is_signed_div(funct_q) && a_q[WIDTH-1]) ? -it_acc : it_acc;
        load    = 1'b0;
        ld_res  = simple_res;
        ld_a    = a;
        ld_b    = b;
        ld_ovf  = simple_ovf;
        ld_dz   = dz;
        if (accept && !start) begin
            load = 1'b1;
        end else if ((state_q == StMul) && (cnt_q == LAST)) begin
            load   = 1'b1;
            ld_res = it_acc_next;
            ld_a   = a_q;
            ld_b   = b_q;
            ld_ovf = 1'b0;
            ld_dz  = 1'b0;
        end else if (state_q == StFix) begin
            load   = 1'b1;
            ld_res = (funct_q inside {FnRem, FnRemu}) ? rem_fix : quo_fix;
            ld_a   = a_q;
            ld_b   = b_q;
            ld_ovf = 1'b0;
            ld_dz  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            funct_q <= FnLoad;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            funct_q <= fn;
            cnt_q   <= '0;
        end else if (step) begin
            cnt_q   <= cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result   <= '0;
            overflow <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b0;
            equal    <= 1'b0;
            greater  <= 1'b0;
            less     <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            result   <= ld_res;
            overflow <= ld_ovf;
            negative <= ld_res[WIDTH-1];
            zero     <= (ld_res == '0);
            equal    <= (ld_a == ld_b);
            greater  <= ($signed(ld_a) > $signed(ld_b));
            less     <= ($signed(ld_a) < $signed(ld_b));
            div_zero <= ld_dz;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded bench for alu_seq at WIDTH = 8: directed corner cases, backpressure,
// mid-operation reset and a randomized run against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned W    = 8;
    localparam int          SMAX = (1 << (W - 1)) - 1;
    localparam int          SMIN = -(1 << (W - 1));

    typedef struct {
        logic [W-1:0] res;
        logic [6:0]   flags;
        int           acc_cyc;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   funct = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         overflow, negative, zero, equal, greater, less, div_zero;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rand_bp = 1'b0;
    exp_t q[$];

    alu_seq #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .funct    (funct),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .overflow (overflow),
        .negative (negative),
        .zero     (zero),
        .equal    (equal),
        .greater  (greater),
        .less     (less),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [6:0] dut_flags();
        return {overflow, negative, zero, equal, greater, less, div_zero};
    endfunction

    // Reference model: plain integer arithmetic on the signed/unsigned operand values.
    function automatic exp_t model(input logic [3:0] f, input logic [W-1:0] av,
                                   input logic [W-1:0] bv);
        exp_t e;
        int   sa, sb, ua, ub, r, sh;
        bit   ovf, dz, sgn, rem;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        ua = int'(av);
        ub = int'(bv);
        sh = ub % W;
        ovf = 1'b0;
        dz = 1'b0;
        r = 0;
        e.lat = 1;
        e.acc_cyc = 0;
        case (f)
            FnLoad: r = ua;
            FnSum: begin r = sa + sb; ovf = (r > SMAX) || (r < SMIN); end
            FnSub: begin r = sa - sb; ovf = (r > SMAX) || (r < SMIN); end
            FnAnd: r = ua & ub;
            FnXor: r = ua ^ ub;
            FnNot: r = ~ua;
            FnInc: r = ua + 1;
            FnOr:  r = ua | ub;
            FnSll: r = ua << sh;
            FnSrl: r = ua >> sh;
            FnSra: r = sa >>> sh;
            FnMul: begin r = ua * ub; e.lat = W + 1; end
            default: begin
                sgn = (f == FnDiv) || (f == FnRem);
                rem = (f == FnRem) || (f == FnRemu);
                if (ub == 0) begin
                    dz = 1'b1;
                    r  = rem ? ua : -1;
                end else if (sgn && sa == SMIN && sb == -1) begin
                    ovf = 1'b1;
                    r   = rem ? 0 : sa;
                end else begin
                    e.lat = W + 2;
                    if (sgn) r = rem ? sa % sb : sa / sb;
                    else     r = rem ? ua % ub : ua / ub;
                end
            end
        endcase
        e.res   = r[W-1:0];
        e.flags = {ovf, e.res[W-1], e.res == '0, sa == sb, sa > sb, sa < sb, dz};
        return e;
    endfunction

    // Presents one request, waits (bounded) for acceptance and queues the expectation.
    task automatic issue(input logic [3:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit directed, input logic [W-1:0] dres);
        exp_t e;
        bit   done;
        int   waited;
        e = model(f, av, bv);
        if (directed) e.res = dres;
        in_valid = 1'b1;
        funct    = f;
        a        = av;
        b        = bv;
        done     = 1'b0;
        waited   = 0;
        while (!done) begin
            @(negedge clk);
            #1;
            if (in_ready) begin
                e.acc_cyc = cyc;
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: in_ready never rose for funct %0d", f);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        funct    = 4'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : bp_gen
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : monitor
        bit ev, er;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                ev = (q.size() > 0) && (cyc >= q[0].acc_cyc + q[0].lat);
                er = (q.size() == 0) || (ev && out_ready);
                check("out_valid", 16'(out_valid), 16'(ev));
                check("in_ready", 16'(in_ready), 16'(er));
                if (ev) begin
                    check("result", 16'(result), 16'(q[0].res));
                    check("flags", 16'(dut_flags()), 16'(q[0].flags));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [3:0]   f;
        logic [W-1:0] av, bv;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 16'(out_valid), 16'd0);
        check("reset_result", 16'(result), 16'd0);
        check("reset_flags", 16'(dut_flags()), 16'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 16'(in_ready), 16'd1);

        issue(FnSum, 8'h7F, 8'h01, 1'b1, 8'h80);
        drain();
        issue(FnMul, 8'h0D, 8'h0B, 1'b1, 8'h8F);
        drain();
        issue(FnDiv,  8'hF9, 8'h02, 1'b1, 8'hFD);
        issue(FnRem,  8'hF9, 8'h02, 1'b1, 8'hFF);
        issue(FnDivu, 8'hF9, 8'h02, 1'b1, 8'h7C);
        issue(FnDivu, 8'h2A, 8'h00, 1'b1, 8'hFF);
        issue(FnDiv,  8'h80, 8'hFF, 1'b1, 8'h80);
        issue(FnRem,  8'h80, 8'hFF, 1'b1, 8'h00);
        drain();

        // Backpressure: result held for three valid cycles, then retire + accept together.
        out_ready = 1'b0;
        issue(FnSra, 8'h90, 8'h02, 1'b1, 8'hE4);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(FnXor, 8'hF0, 8'h0F, 1'b1, 8'hFF);
        drain();

        // Reset in the middle of a multiply: nothing may come out afterwards.
        issue(FnMul, 8'h5A, 8'h33, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        q.delete();
        #1;
        check("midreset_out_valid", 16'(out_valid), 16'd0);
        check("midreset_result", 16'(result), 16'd0);
        check("midreset_flags", 16'(dut_flags()), 16'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_midreset", 16'(in_ready), 16'd1);
        repeat (12) @(posedge clk);
        #1;
        issue(FnInc, 8'hFF, 8'h00, 1'b1, 8'h00);
        drain();

        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            f  = 4'($urandom_range(0, 15));
            av = W'($urandom);
            bv = W'($urandom);
            case ($urandom_range(0, 7))
                0: bv = '0;
                1: begin av = 8'h80; bv = 8'hFF; end
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            issue(f, av, bv, 1'b0, 8'h00);
        end
        drain();
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
